// File: rtl/cvt12_cfu_if.sv
// CFU-L2 request/response channel between an initiator and the cvt12 adapter.
// The initiator holds the master side; the adapter holds the slave side.
interface cvt12_cfu_if #(
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_DATA_W     = 32,
    parameter int CFU_CFU_ID_W   = 1,
    parameter int CFU_STATE_ID_W = 1,
    parameter int CFU_STATUS_W   = 3
);
    logic                      req_valid;
    logic                      req_ready;
    logic [CFU_CFU_ID_W-1:0]   req_cfu;
    logic [CFU_STATE_ID_W-1:0] req_state;
    logic [CFU_FUNC_ID_W-1:0]  req_func;
    logic [CFU_DATA_W-1:0]     req_data0;
    logic [CFU_DATA_W-1:0]     req_data1;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [CFU_STATUS_W-1:0]   resp_status;
    logic [CFU_DATA_W-1:0]     resp_data;

    modport master (
        output req_valid, req_cfu, req_state, req_func, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_cfu, req_state, req_func, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_status, resp_data
    );
endinterface

// File: rtl/cvt12_cfu.sv
// CFU-L2 to CFU-L1 adapter: forwards requests to a fixed-latency subordinate and
// buffers its responses in a credit-protected FIFO so none is ever dropped.
module cvt12_cfu #(
    parameter int CFU_LATENCY    = 2,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_DATA_W     = 32,
    parameter int CFU_CFU_ID_W   = 1,
    parameter int CFU_STATE_ID_W = 1,
    parameter int CFU_STATUS_W   = 3,
    parameter int FIFO_DEPTH     = CFU_LATENCY + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    cvt12_cfu_if.slave                bus,
    output logic                      t_clk_en,
    output logic                      t_req_valid,
    output logic [CFU_CFU_ID_W-1:0]   t_req_cfu,
    output logic [CFU_STATE_ID_W-1:0] t_req_state,
    output logic [CFU_FUNC_ID_W-1:0]  t_req_func,
    output logic [CFU_DATA_W-1:0]     t_req_data0,
    output logic [CFU_DATA_W-1:0]     t_req_data1,
    input  logic                      t_resp_valid,
    input  logic [CFU_STATUS_W-1:0]   t_resp_status,
    input  logic [CFU_DATA_W-1:0]     t_resp_data
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = CFU_STATUS_W + CFU_DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic             issue;
    logic             wr;
    logic             wr_en;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Ready comes only from the registered credit count, never from resp_ready.
    assign bus.req_ready = clk_en & (count < DEPTH_C);
    assign issue         = bus.req_valid & bus.req_ready;

    assign t_clk_en    = clk_en;
    assign t_req_valid = issue;
    assign t_req_cfu   = bus.req_cfu;
    assign t_req_state = bus.req_state;
    assign t_req_func  = bus.req_func;
    assign t_req_data0 = bus.req_data0;
    assign t_req_data1 = bus.req_data1;

    assign bus.resp_valid                  = clk_en & (occ != '0);
    assign {bus.resp_status, bus.resp_data} = mem[rd_ptr];
    assign pop   = bus.resp_valid & bus.resp_ready;
    assign wr_en = wr & clk_en;

    // Issue delay line tracking when the subordinate's response is due.
    generate
        if (CFU_LATENCY == 0) begin : g_bypass
            assign wr = issue;
        end else begin : g_line
            logic [CFU_LATENCY-1:0] vld_line;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_line <= '0;
                end else if (clk_en) begin
                    vld_line[0] <= issue;
                    for (int i = 1; i < CFU_LATENCY; i++) vld_line[i] <= vld_line[i-1];
                end
            end
            assign wr = vld_line[CFU_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CNT_W'(issue) - CNT_W'(pop);
            occ   <= occ + CNT_W'(wr_en) - CNT_W'(pop);
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {t_resp_status, t_resp_data};
    end

    a_sub_valid: assert property (@(posedge clk) disable iff (rst) t_resp_valid == wr);
    a_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(wr_en && !pop && occ == DEPTH_C));
    a_credits:   assert property (@(posedge clk) disable iff (rst) (count <= DEPTH_C) && (occ <= count));
endmodule

// File: tb/tb_cvt12_cfu.sv
// Randomized bench for cvt12_cfu: two adapters (L=2/depth 4 and L=0/depth 3) driven
// side by side, each against a transaction-level queue model of the adapter.
module tb_cvt12_cfu;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        resp_ready;
    logic [0:0]  req_cfu;
    logic [0:0]  req_state;
    logic [9:0]  req_func;
    logic [31:0] req_data0;
    logic [31:0] req_data1;

    cvt12_cfu_if #(.CFU_STATUS_W(3)) bus_a ();
    cvt12_cfu_if #(.CFU_STATUS_W(3)) bus_b ();

    assign bus_a.req_valid = req_valid;  assign bus_b.req_valid = req_valid;
    assign bus_a.req_cfu   = req_cfu;    assign bus_b.req_cfu   = req_cfu;
    assign bus_a.req_state = req_state;  assign bus_b.req_state = req_state;
    assign bus_a.req_func  = req_func;   assign bus_b.req_func  = req_func;
    assign bus_a.req_data0 = req_data0;  assign bus_b.req_data0 = req_data0;
    assign bus_a.req_data1 = req_data1;  assign bus_b.req_data1 = req_data1;
    assign bus_a.resp_ready = resp_ready;
    assign bus_b.resp_ready = resp_ready;

    logic        sa_clk_en, sa_req_valid, sa_resp_valid;
    logic [0:0]  sa_cfu, sa_state;
    logic [9:0]  sa_func;
    logic [31:0] sa_d0, sa_d1, sa_resp_data;
    logic [2:0]  sa_resp_status;
    logic        sb_clk_en, sb_req_valid, sb_resp_valid;
    logic [0:0]  sb_cfu, sb_state;
    logic [9:0]  sb_func;
    logic [31:0] sb_d0, sb_d1, sb_resp_data;
    logic [2:0]  sb_resp_status;

    cvt12_cfu #(.CFU_LATENCY(2), .CFU_STATUS_W(3), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_a.slave),
        .t_clk_en(sa_clk_en), .t_req_valid(sa_req_valid), .t_req_cfu(sa_cfu),
        .t_req_state(sa_state), .t_req_func(sa_func), .t_req_data0(sa_d0), .t_req_data1(sa_d1),
        .t_resp_valid(sa_resp_valid), .t_resp_status(sa_resp_status), .t_resp_data(sa_resp_data)
    );

    cvt12_cfu #(.CFU_LATENCY(0), .CFU_STATUS_W(3), .FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_b.slave),
        .t_clk_en(sb_clk_en), .t_req_valid(sb_req_valid), .t_req_cfu(sb_cfu),
        .t_req_state(sb_state), .t_req_func(sb_func), .t_req_data0(sb_d0), .t_req_data1(sb_d1),
        .t_resp_valid(sb_resp_valid), .t_resp_status(sb_resp_status), .t_resp_data(sb_resp_data)
    );

    // Subordinate A: two-cycle adder returning func[2:0] as status.
    logic        sa_v1, sa_v2;
    logic [34:0] sa_r1, sa_r2;
    always @(posedge clk) begin
        if (rst) begin
            sa_v1 <= 1'b0;
            sa_v2 <= 1'b0;
        end else if (sa_clk_en) begin
            sa_v1 <= sa_req_valid;
            sa_r1 <= {sa_func[2:0], sa_d0 + sa_d1};
            sa_v2 <= sa_v1;
            sa_r2 <= sa_r1;
        end
    end
    assign sa_resp_valid = sa_v2;
    assign {sa_resp_status, sa_resp_data} = sa_r2;

    // Subordinate B: zero-latency adder.
    assign sb_resp_valid  = sb_req_valid;
    assign sb_resp_status = sb_func[2:0];
    assign sb_resp_data   = sb_d0 + sb_d1;

    logic        o_ready  [2];
    logic        o_rvalid [2];
    logic        o_tvalid [2];
    logic        o_tclken [2];
    logic [2:0]  o_st     [2];
    logic [31:0] o_dt     [2];
    assign o_ready[0]  = bus_a.req_ready;   assign o_ready[1]  = bus_b.req_ready;
    assign o_rvalid[0] = bus_a.resp_valid;  assign o_rvalid[1] = bus_b.resp_valid;
    assign o_st[0]     = bus_a.resp_status; assign o_st[1]     = bus_b.resp_status;
    assign o_dt[0]     = bus_a.resp_data;   assign o_dt[1]     = bus_b.resp_data;
    assign o_tvalid[0] = sa_req_valid;      assign o_tvalid[1] = sb_req_valid;
    assign o_tclken[0] = sa_clk_en;         assign o_tclken[1] = sb_clk_en;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction
    function automatic int dep_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    // Model: every accepted request is queued with the enabled-cycle count at
    // which its response may first be shown; popped in order.
    int          ecyc [2];
    int          head [2];
    int          tail [2];
    logic [2:0]  m_st  [2][64];
    logic [31:0] m_dt  [2][64];
    int          m_due [2][64];
    logic        iss [2];
    logic        pp  [2];
    logic        armed = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int inst, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got=%0h want=%0h", tag, inst, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin : chk_inst
            logic er, ev;
            er = clk_en && ((tail[i] - head[i]) < dep_of(i));
            ev = clk_en && (tail[i] != head[i]) && (m_due[i][head[i] % 64] <= ecyc[i]);
            if (armed) begin
                check("req_ready",   i, 64'(o_ready[i]),  64'(er));
                check("resp_valid",  i, 64'(o_rvalid[i]), 64'(ev));
                check("t_req_valid", i, 64'(o_tvalid[i]), 64'(req_valid && er));
                check("t_clk_en",    i, 64'(o_tclken[i]), 64'(clk_en));
                if (ev) begin
                    check("resp_status", i, 64'(o_st[i]), 64'(m_st[i][head[i] % 64]));
                    check("resp_data",   i, 64'(o_dt[i]), 64'(m_dt[i][head[i] % 64]));
                end
            end
            iss[i] = armed && req_valid && er;
            pp[i]  = armed && ev && resp_ready;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                head[i] <= 0;
                tail[i] <= 0;
            end else if (clk_en) begin
                if (iss[i]) begin
                    m_st[i][tail[i] % 64]  <= req_func[2:0];
                    m_dt[i][tail[i] % 64]  <= req_data0 + req_data1;
                    m_due[i][tail[i] % 64] <= ecyc[i] + lat_of(i) + 1;
                    tail[i] <= tail[i] + 1;
                end
                if (pp[i]) head[i] <= head[i] + 1;
                ecyc[i] <= ecyc[i] + 1;
            end
        end
    end

    task automatic cyc(input logic v, input logic rr, input logic ce);
        req_valid  = v;
        resp_ready = rr;
        clk_en     = ce;
        req_cfu    = 1'($urandom);
        req_state  = 1'($urandom);
        req_func   = 10'($urandom);
        req_data0  = $urandom;
        req_data1  = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ecyc[i] = 0;
            head[i] = 0;
            tail[i] = 0;
            iss[i]  = 1'b0;
            pp[i]   = 1'b0;
        end
        rst = 1'b1;
        clk_en = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        req_cfu = '0; req_state = '0; req_func = '0; req_data0 = '0; req_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;

        // single request, then stream, then back-pressure fill and drain
        cyc(1'b1, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b1, 1'b1);
        repeat (20) cyc(1'b1, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b1, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);

        repeat (80) cyc(1'($urandom), 1'($urandom), 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);

        // reset with responses buffered and in flight
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        repeat (10) cyc(1'b0, 1'b1, 1'b1);

        // clock-enable stall with two requests in flight
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b1);

        repeat (300) cyc(1'($urandom), ($urandom % 4) != 0, ($urandom % 5) != 0);
        repeat (12) cyc(1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
